// File: rtl/comparator_arbiter_if.sv
// Request/response bundle for comparator_arbiter: two requesters (0 = branch unit,
// 1 = SLT/SLTU path), each with a valid/ready request channel and a valid/ready result channel.
interface comparator_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_data1;
  logic [WIDTH-1:0] req0_data2;
  logic [2:0]       req0_func3;
  logic [TAG_W-1:0] req0_tag;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_data1;
  logic [WIDTH-1:0] req1_data2;
  logic [2:0]       req1_func3;
  logic [TAG_W-1:0] req1_tag;

  logic             rsp0_valid;
  logic             rsp0_ready;
  logic             rsp0_result;
  logic [TAG_W-1:0] rsp0_tag;

  logic             rsp1_valid;
  logic             rsp1_ready;
  logic             rsp1_result;
  logic [TAG_W-1:0] rsp1_tag;

  modport master (
    output req0_valid, req0_data1, req0_data2, req0_func3, req0_tag,
    output req1_valid, req1_data1, req1_data2, req1_func3, req1_tag,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_result, rsp0_tag,
    input  rsp1_valid, rsp1_result, rsp1_tag
  );

  modport slave (
    input  req0_valid, req0_data1, req0_data2, req0_func3, req0_tag,
    input  req1_valid, req1_data1, req1_data2, req1_func3, req1_tag,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_result, rsp0_tag,
    output rsp1_valid, rsp1_result, rsp1_tag
  );
endinterface

// File: rtl/comparator_arbiter.sv
// Two-port round-robin arbiter sharing one RV32I branch comparator through an S1/S2 pipeline.
// Define COMPARATOR_ARB_STATS_EN to add saturating grant/conflict counters.
module comparator_arbiter #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  comparator_arbiter_if.slave  bus
`ifdef COMPARATOR_ARB_STATS_EN
  ,
  output logic [31:0]          stat_grant0,
  output logic [31:0]          stat_grant1,
  output logic [31:0]          stat_conflict
`endif
);

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_data1_q, s1_data1_d;
  logic [WIDTH-1:0] s1_data2_q, s1_data2_d;
  logic [2:0]       s1_func3_q, s1_func3_d;
  logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;
  port_e            s1_src_q,   s1_src_d;

  logic             s2_valid_q,  s2_valid_d;
  logic             s2_result_q, s2_result_d;
  logic [TAG_W-1:0] s2_tag_q,    s2_tag_d;
  port_e            s2_src_q,    s2_src_d;

  port_e            last_grant_q, last_grant_d;

  port_e            grant;
  logic             s2_adv;
  logic             s1_adv;
  logic             ready0;
  logic             ready1;
  logic             acc0;
  logic             acc1;
  logic             accept;

  // Signed lt is derived from the MSBs first, falling back to the unsigned low bits.
  function automatic logic cmp_result(input logic [WIDTH-1:0] a,
                                      input logic [WIDTH-1:0] b,
                                      input logic [2:0]       f);
    logic eq;
    logic ult;
    logic slt;
    logic lt_sel;
    eq  = (a == b);
    ult = (a < b);
    if (a[WIDTH-1] != b[WIDTH-1]) slt = a[WIDTH-1];
    else                          slt = (a[WIDTH-2:0] < b[WIDTH-2:0]);
    lt_sel = f[1] ? ult : slt;
    return f[2] ? (lt_sel ^ f[0]) : (eq ^ f[0]);
  endfunction

  always_comb begin
    s2_adv = !s2_valid_q || ((s2_src_q == PORT1) ? bus.rsp1_ready : bus.rsp0_ready);
    s1_adv = !s1_valid_q || s2_adv;

    if (bus.req0_valid && bus.req1_valid) grant = (last_grant_q == PORT0) ? PORT1 : PORT0;
    else if (bus.req1_valid)              grant = PORT1;
    else                                  grant = PORT0;

    // Ready is held low while reset is asserted, even though the pipeline looks empty.
    ready0 = rst_n && s1_adv && (grant == PORT0);
    ready1 = rst_n && s1_adv && (grant == PORT1);
    acc0   = bus.req0_valid && ready0;
    acc1   = bus.req1_valid && ready1;
    accept = acc0 || acc1;
  end

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_data1_d   = s1_data1_q;
    s1_data2_d   = s1_data2_q;
    s1_func3_d   = s1_func3_q;
    s1_tag_d     = s1_tag_q;
    s1_src_d     = s1_src_q;
    s2_valid_d   = s2_valid_q;
    s2_result_d  = s2_result_q;
    s2_tag_d     = s2_tag_q;
    s2_src_d     = s2_src_q;
    last_grant_d = last_grant_q;

    if (s1_adv) s1_valid_d = accept;
    if (accept) begin
      s1_src_d     = grant;
      last_grant_d = grant;
      if (grant == PORT1) begin
        s1_data1_d = bus.req1_data1;
        s1_data2_d = bus.req1_data2;
        s1_func3_d = bus.req1_func3;
        s1_tag_d   = bus.req1_tag;
      end else begin
        s1_data1_d = bus.req0_data1;
        s1_data2_d = bus.req0_data2;
        s1_func3_d = bus.req0_func3;
        s1_tag_d   = bus.req0_tag;
      end
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_result_d = cmp_result(s1_data1_q, s1_data2_q, s1_func3_q);
        s2_tag_d    = s1_tag_q;
        s2_src_d    = s1_src_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_data1_q   <= '0;
      s1_data2_q   <= '0;
      s1_func3_q   <= '0;
      s1_tag_q     <= '0;
      s1_src_q     <= PORT0;
      s2_valid_q   <= 1'b0;
      s2_result_q  <= 1'b0;
      s2_tag_q     <= '0;
      s2_src_q     <= PORT0;
      last_grant_q <= PORT1;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_data1_q   <= s1_data1_d;
      s1_data2_q   <= s1_data2_d;
      s1_func3_q   <= s1_func3_d;
      s1_tag_q     <= s1_tag_d;
      s1_src_q     <= s1_src_d;
      s2_valid_q   <= s2_valid_d;
      s2_result_q  <= s2_result_d;
      s2_tag_q     <= s2_tag_d;
      s2_src_q     <= s2_src_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.req0_ready  = ready0;
  assign bus.req1_ready  = ready1;
  assign bus.rsp0_valid  = s2_valid_q && (s2_src_q == PORT0);
  assign bus.rsp1_valid  = s2_valid_q && (s2_src_q == PORT1);
  assign bus.rsp0_result = s2_result_q;
  assign bus.rsp1_result = s2_result_q;
  assign bus.rsp0_tag    = s2_tag_q;
  assign bus.rsp1_tag    = s2_tag_q;

`ifdef COMPARATOR_ARB_STATS_EN
  logic [31:0] stat_grant0_q,   stat_grant0_d;
  logic [31:0] stat_grant1_q,   stat_grant1_d;
  logic [31:0] stat_conflict_q, stat_conflict_d;

  always_comb begin
    stat_grant0_d   = stat_grant0_q;
    stat_grant1_d   = stat_grant1_q;
    stat_conflict_d = stat_conflict_q;
    if (acc0 && (stat_grant0_q != '1)) stat_grant0_d = stat_grant0_q + 32'd1;
    if (acc1 && (stat_grant1_q != '1)) stat_grant1_d = stat_grant1_q + 32'd1;
    if (bus.req0_valid && bus.req1_valid && accept && (stat_conflict_q != '1))
      stat_conflict_d = stat_conflict_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_grant0_q   <= '0;
      stat_grant1_q   <= '0;
      stat_conflict_q <= '0;
    end else begin
      stat_grant0_q   <= stat_grant0_d;
      stat_grant1_q   <= stat_grant1_d;
      stat_conflict_q <= stat_conflict_d;
    end
  end

  assign stat_grant0   = stat_grant0_q;
  assign stat_grant1   = stat_grant1_q;
  assign stat_conflict = stat_conflict_q;
`endif

endmodule

// File: tb/tb_comparator_arbiter.sv
// Self-checking bench for comparator_arbiter: directed scenarios plus a random phase, all
// outputs checked every cycle against an in-order transaction model of the shared pipeline.
module tb_comparator_arbiter;
  localparam int WIDTH = 32;
  localparam int TAG_W = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  comparator_arbiter_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

`ifdef COMPARATOR_ARB_STATS_EN
  logic [31:0] stat_grant0;
  logic [31:0] stat_grant1;
  logic [31:0] stat_conflict;
`endif

  comparator_arbiter #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef COMPARATOR_ARB_STATS_EN
    ,
    .stat_grant0   (stat_grant0),
    .stat_grant1   (stat_grant1),
    .stat_conflict (stat_conflict)
`endif
  );

  typedef struct {
    bit             src;
    bit             result;
    logic [TAG_W-1:0] tag;
    int             due;
  } txn_t;

  txn_t q[$];
  int   grant_log[$];
  bit   last_m = 1'b1;
  int   cyc = 0;
  bit   acc0, acc1;
  int   rsp_cnt0 = 0;
  int   rsp_cnt1 = 0;
  int   n_pass = 0;
  int   n_total = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Architectural RV32I branch semantics; 010/011 alias EQ/NE.
  function automatic bit ref_cmp(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
    case (f)
      3'b000, 3'b010: return a == b;
      3'b001, 3'b011: return a != b;
      3'b100:         return $signed(a) <  $signed(b);
      3'b101:         return $signed(a) >= $signed(b);
      3'b110:         return a <  b;
      default:        return a >= b;
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Model: transactions leave in acceptance order, each due two cycles after acceptance;
  // at most two in flight, a third fits only while the head is being consumed.
  always @(negedge clk) begin
    bit exp_v0, exp_v1, head_rdy, can, w;
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (!rst_n) begin
      q.delete();
      last_m = 1'b1;
      chk("rst_rsp0_valid", bus.rsp0_valid, 0);
      chk("rst_rsp1_valid", bus.rsp1_valid, 0);
      chk("rst_req0_ready", bus.req0_ready, 0);
      chk("rst_req1_ready", bus.req1_ready, 0);
      chk("rst_rsp0_result", bus.rsp0_result, 0);
      chk("rst_rsp1_tag", bus.rsp1_tag, 0);
    end else begin
      exp_v0   = (q.size() > 0) && (q[0].due <= cyc) && (q[0].src == 1'b0);
      exp_v1   = (q.size() > 0) && (q[0].due <= cyc) && (q[0].src == 1'b1);
      head_rdy = (q.size() > 0) && (q[0].src ? bus.rsp1_ready : bus.rsp0_ready);
      chk("rsp0_valid", bus.rsp0_valid, exp_v0);
      chk("rsp1_valid", bus.rsp1_valid, exp_v1);
      if (exp_v0) begin
        chk("rsp0_result", bus.rsp0_result, q[0].result);
        chk("rsp0_tag", bus.rsp0_tag, q[0].tag);
      end
      if (exp_v1) begin
        chk("rsp1_result", bus.rsp1_result, q[0].result);
        chk("rsp1_tag", bus.rsp1_tag, q[0].tag);
      end
      can = (q.size() < 2) || head_rdy;
      w   = (bus.req0_valid && bus.req1_valid) ? !last_m : bus.req1_valid;
      chk("req0_ready", bus.req0_ready, can && !w);
      chk("req1_ready", bus.req1_ready, can && w);
      if ((exp_v0 || exp_v1) && head_rdy) begin
        if (q[0].src) rsp_cnt1++;
        else          rsp_cnt0++;
        void'(q.pop_front());
      end
      acc0 = bus.req0_valid && bus.req0_ready;
      acc1 = bus.req1_valid && bus.req1_ready;
      if (acc0) begin
        q.push_back('{1'b0, ref_cmp(bus.req0_data1, bus.req0_data2, bus.req0_func3), bus.req0_tag, cyc + 2});
        grant_log.push_back(0);
        last_m = 1'b0;
      end
      if (acc1) begin
        q.push_back('{1'b1, ref_cmp(bus.req1_data1, bus.req1_data2, bus.req1_func3), bus.req1_tag, cyc + 2});
        grant_log.push_back(1);
        last_m = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (acc0) bus.req0_valid = 1'b0;
    if (acc1) bus.req1_valid = 1'b0;
  endtask

  task automatic load0(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f, input logic [TAG_W-1:0] t);
    bus.req0_valid = 1'b1; bus.req0_data1 = a; bus.req0_data2 = b; bus.req0_func3 = f; bus.req0_tag = t;
  endtask

  task automatic load1(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f, input logic [TAG_W-1:0] t);
    bus.req1_valid = 1'b1; bus.req1_data1 = a; bus.req1_data2 = b; bus.req1_func3 = f; bus.req1_tag = t;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((bus.req0_valid || bus.req1_valid || q.size() != 0) && n < 100) begin
      tick();
      n++;
    end
    chk(tag, (n < 100), 1);
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 3))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return $urandom;
      default: return $urandom & 32'hF;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] op_a [8];
    logic [31:0] op_b [8];
    logic [2:0]  op_f [8];
    int c0, c1;
    int t0, t1;
    logic [31:0] ra, rb;

    bus.req0_valid = 0; bus.req0_data1 = '0; bus.req0_data2 = '0; bus.req0_func3 = '0; bus.req0_tag = '0;
    bus.req1_valid = 0; bus.req1_data1 = '0; bus.req1_data2 = '0; bus.req1_func3 = '0; bus.req1_tag = '0;
    bus.rsp0_ready = 1; bus.rsp1_ready = 1;
    #1 rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;

    // 1: single BLT / BLTU, two-cycle latency
    load0(32'hFFFF_FFFF, 32'h1, 3'b100, 4'd3);
    tick(); tick();
    chk("s1_blt_valid", bus.rsp0_valid, 1);
    chk("s1_blt_result", bus.rsp0_result, 1);
    chk("s1_blt_tag", bus.rsp0_tag, 3);
    load0(32'hFFFF_FFFF, 32'h1, 3'b110, 4'd4);
    tick(); tick();
    chk("s1_bltu_valid", bus.rsp0_valid, 1);
    chk("s1_bltu_result", bus.rsp0_result, 0);
    chk("s1_bltu_tag", bus.rsp0_tag, 4);
    wait_idle("s1_drain");

    // 2: continuous contention after a fresh reset
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
    grant_log.delete();
    t0 = 0; t1 = 8;
    load0(32'd5, 32'd5, 3'b000, 4'(t0++));
    load1(32'd5, 32'd5, 3'b001, 4'(t1++));
    for (int i = 0; i < 20 && grant_log.size() < 6; i++) begin
      tick();
      if (grant_log.size() >= 6) begin
        bus.req0_valid = 0; bus.req1_valid = 0;
      end else begin
        if (!bus.req0_valid) load0(32'd5, 32'd5, 3'b000, 4'(t0++));
        if (!bus.req1_valid) load1(32'd5, 32'd5, 3'b001, 4'(t1++));
      end
    end
    chk("s2_grant_count", grant_log.size(), 6);
    for (int j = 0; j < 6 && j < grant_log.size(); j++) chk($sformatf("s2_grant%0d", j), grant_log[j], j % 2);
    wait_idle("s2_drain");
`ifdef COMPARATOR_ARB_STATS_EN
    chk("stat_grant0", stat_grant0, 3);
    chk("stat_grant1", stat_grant1, 3);
    chk("stat_conflict", stat_conflict, 6);
`endif

    // 3: port-1 result stalled in S2 blocks port 0
    c0 = rsp_cnt0; c1 = rsp_cnt1;
    bus.rsp1_ready = 0;
    load1(32'd3, 32'd7, 3'b100, 4'd9);
    tick();
    load0(32'd1, 32'd2, 3'b110, 4'd1);
    tick();
    load0(32'd2, 32'd2, 3'b001, 4'd2);
    chk("s3_rsp1_valid", bus.rsp1_valid, 1);
    chk("s3_rsp1_result", bus.rsp1_result, 1);
    chk("s3_rsp1_tag", bus.rsp1_tag, 9);
    repeat (3) tick();
    chk("s3_req0_blocked", bus.req0_ready, 0);
    chk("s3_rsp1_hold_result", bus.rsp1_result, 1);
    chk("s3_rsp1_hold_tag", bus.rsp1_tag, 9);
    bus.rsp1_ready = 1;
    wait_idle("s3_drain");
    chk("s3_rsp0_count", rsp_cnt0 - c0, 2);
    chk("s3_rsp1_count", rsp_cnt1 - c1, 1);

    // 4: eight back-to-back port-0 requests
    op_a = '{32'h8000_0000, 32'h8000_0000, 32'd9, 32'd9, 32'hFFFF_FFFF, 32'd0, 32'h7FFF_FFFF, 32'd4};
    op_b = '{32'h0, 32'h0, 32'd9, 32'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'd4};
    op_f = '{3'b101, 3'b111, 3'b010, 3'b011, 3'b000, 3'b100, 3'b110, 3'b101};
    c0 = rsp_cnt0;
    load0(op_a[0], op_b[0], op_f[0], 4'd0);
    for (int i = 1; i < 8; i++) begin
      tick();
      load0(op_a[i], op_b[i], op_f[i], 4'(i));
    end
    repeat (3) tick();
    chk("s4_stream_count", rsp_cnt0 - c0, 8);
    wait_idle("s4_drain");

    // 5: reset with S1 and S2 both occupied
    bus.rsp0_ready = 0;
    load0(32'd1, 32'd1, 3'b000, 4'd2);
    tick();
    load0(32'd2, 32'd3, 3'b100, 4'd5);
    tick();
    load0(32'd4, 32'd4, 3'b001, 4'd6);
    chk("s5_pre_rsp0_valid", bus.rsp0_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("s5_rst_rsp0_valid", bus.rsp0_valid, 0);
    chk("s5_rst_rsp1_valid", bus.rsp1_valid, 0);
    chk("s5_rst_req0_ready", bus.req0_ready, 0);
    bus.req0_valid = 0;
    tick(); tick();
    bus.rsp0_ready = 1;
    rst_n = 1'b1;
    grant_log.delete();
    load0(32'd7, 32'd7, 3'b000, 4'd1);
    load1(32'd7, 32'd8, 3'b110, 4'd2);
    tick();
    chk("s5_first_grant_seen", grant_log.size(), 1);
    if (grant_log.size() > 0) chk("s5_first_grant", grant_log[0], 0);
    wait_idle("s5_drain");

`ifdef COMPARATOR_ARB_STATS_EN
    // 6: saturation of grant counter
    force dut.stat_grant0_q = 32'hFFFF_FFFE;
    #1 release dut.stat_grant0_q;
    load0(32'd1, 32'd1, 3'b000, 4'd1);
    tick();
    load0(32'd1, 32'd1, 3'b000, 4'd2);
    tick();
    wait_idle("s6_drain");
    chk("stat_grant0_sat", stat_grant0, 32'hFFFF_FFFF);
`endif

    // random traffic with random response backpressure
    for (int i = 0; i < 400; i++) begin
      bus.rsp0_ready = ($urandom_range(0, 3) != 0);
      bus.rsp1_ready = ($urandom_range(0, 3) != 0);
      if (!bus.req0_valid && $urandom_range(0, 2) != 0) begin
        ra = rand_word();
        rb = ($urandom_range(0, 1) != 0) ? ra : rand_word();
        load0(ra, rb, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
      end
      if (!bus.req1_valid && $urandom_range(0, 2) != 0) begin
        ra = rand_word();
        rb = ($urandom_range(0, 1) != 0) ? ra : rand_word();
        load1(ra, rb, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
      end
      tick();
    end
    bus.rsp0_ready = 1; bus.rsp1_ready = 1;
    wait_idle("rand_drain");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
